// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//   Shared definitions for the multi-cycle control sequencer:
//   - state_t        : sequencer states
//   - instr_class_t  : instruction classes recognised by the decoder
//   - opcode, ALU opcode and immediate-format constants
//   - bit positions inside the datapath status vector {p, o, cout, n, z}
//   - classify()     : maps an instruction word to its class
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ECALL,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [6:0]  OPC_R      = 7'b0110011;
  localparam logic [6:0]  OPC_I      = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam int unsigned STATUS_Z    = 0;
  localparam int unsigned STATUS_N    = 1;
  localparam int unsigned STATUS_COUT = 2;
  localparam int unsigned STATUS_O    = 3;
  localparam int unsigned STATUS_P    = 4;

  // ECALL is matched on the full word; any other SYSTEM encoding is illegal.
  function automatic instr_class_t classify(input logic [31:0] word);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    if (word == ECALL_WORD) begin
      cls = CLS_ECALL;
    end else begin
      case (word[6:0])
        OPC_R:      cls = CLS_R;
        OPC_I:      cls = CLS_I;
        OPC_LOAD:   cls = CLS_LOAD;
        OPC_STORE:  cls = CLS_STORE;
        OPC_BRANCH: cls = CLS_BRANCH;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
//   Purely combinational ALU control decode.
//   Ports:
//     cls        in  instruction class
//     funct3     in  instr[14:12]
//     funct7_b5  in  instr[30]
//     aluop      out ALU opcode
//     br_illegal out branch with an unsupported funct3
module alu_decoder
  import ctrl_pkg::*;
(
  input  instr_class_t cls,
  input  logic [2:0]   funct3,
  input  logic         funct7_b5,
  output logic [3:0]   aluop,
  output logic         br_illegal
);

  always_comb begin
    aluop      = ALU_ADD;
    br_illegal = 1'b0;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          // funct7[5] selects SUB only for register-register ops; for
          // I-type bit 30 is immediate data.
          3'b000:  aluop = (cls == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  aluop = ALU_SLL;
          // No unsigned compare in the ALU; SLTU shares the SLT code.
          3'b010,
          3'b011:  aluop = ALU_SLT;
          3'b100:  aluop = ALU_XOR;
          3'b101:  aluop = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  aluop = ALU_OR;
          default: aluop = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        aluop      = ALU_SUB;
        br_illegal = !(funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
      end
      default: aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm
//   Multi-cycle control sequencer for the single-cycle datapath.
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, HALT absorbing.
//   Ports:
//     clk, rst (async, active low)
//     instr       in  instruction word from the datapath (latched in FETCH)
//     status      in  {p, o, cout, n, z}
//     pcsrc       out 0: PC+4, 1: PC+imm
//     alusrc      out 0: immediate, 1: rs2
//     aluop       out ALU opcode
//     memrw       out 1: RAM write
//     wb          out 0: RAM data, 1: ALU result
//     regrw       out register-file write enable
//     immgen_ctrl out immediate format (00 I, 01 S, 10 B)
//     pc_we       out one-cycle PC update strobe
//     halted      out sticky halt (ECALL or illegal)
//     illegal     out sticky illegal-instruction flag
//     instret     out retired-instruction count (wraps)
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic [4:0]           status,
  output logic                 pcsrc,
  output logic                 alusrc,
  output logic [3:0]           aluop,
  output logic                 memrw,
  output logic                 wb,
  output logic                 regrw,
  output logic [1:0]           immgen_ctrl,
  output logic                 pc_we,
  output logic                 halted,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t       state, state_nxt;
  logic [31:0]  ir;
  instr_class_t cls;
  logic [3:0]   dec_aluop;
  logic         br_illegal;
  logic         br_taken;

  logic         alusrc_nxt, memrw_nxt, wb_nxt, regrw_nxt, pc_we_nxt;
  logic [3:0]   aluop_nxt;
  logic [1:0]   imm_nxt;
  logic         set_halt, set_illegal;

  logic         unused_status;
  assign unused_status = status[STATUS_P] ^ status[STATUS_COUT];

  assign cls = classify(ir);

  alu_decoder u_alu_decoder (
    .cls        (cls),
    .funct3     (ir[14:12]),
    .funct7_b5  (ir[30]),
    .aluop      (dec_aluop),
    .br_illegal (br_illegal)
  );

  always_comb begin
    case (ir[14:12])
      3'b000:  br_taken = status[STATUS_Z];
      3'b001:  br_taken = !status[STATUS_Z];
      3'b100:  br_taken = status[STATUS_N] ^ status[STATUS_O];
      3'b101:  br_taken = !(status[STATUS_N] ^ status[STATUS_O]);
      default: br_taken = 1'b0;
    endcase
  end

  // The branch compare result only exists while the datapath performs the
  // EXEC-cycle subtraction, so pcsrc is the single output that looks at
  // status in the same cycle; it is still qualified by registered state.
  assign pcsrc = (state == ST_EXEC) && (cls == CLS_BRANCH) && br_taken;

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_nxt   = state;
    alusrc_nxt  = 1'b0;
    aluop_nxt   = ALU_ADD;
    memrw_nxt   = 1'b0;
    wb_nxt      = 1'b0;
    regrw_nxt   = 1'b0;
    imm_nxt     = IMM_I;
    pc_we_nxt   = 1'b0;
    set_halt    = 1'b0;
    set_illegal = 1'b0;
    case (state)
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (cls)
          CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH: begin
            state_nxt  = ST_EXEC;
            aluop_nxt  = dec_aluop;
            alusrc_nxt = (cls == CLS_R) || (cls == CLS_BRANCH);
            imm_nxt    = (cls == CLS_STORE)  ? IMM_S :
                         (cls == CLS_BRANCH) ? IMM_B : IMM_I;
            pc_we_nxt  = (cls == CLS_BRANCH) && !br_illegal;
          end
          CLS_ECALL: begin
            state_nxt = ST_HALT;
            set_halt  = 1'b1;
          end
          default: begin
            state_nxt   = ST_HALT;
            set_halt    = 1'b1;
            set_illegal = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        case (cls)
          CLS_BRANCH: begin
            if (br_illegal) begin
              state_nxt   = ST_HALT;
              set_halt    = 1'b1;
              set_illegal = 1'b1;
            end else begin
              state_nxt = ST_FETCH;
            end
          end
          CLS_LOAD, CLS_STORE: begin
            state_nxt = ST_MEM;
            aluop_nxt = dec_aluop;
            imm_nxt   = (cls == CLS_STORE) ? IMM_S : IMM_I;
            memrw_nxt = (cls == CLS_STORE);
            pc_we_nxt = (cls == CLS_STORE);
          end
          default: begin
            state_nxt  = ST_WB;
            aluop_nxt  = dec_aluop;
            alusrc_nxt = (cls == CLS_R);
            wb_nxt     = 1'b1;
            regrw_nxt  = 1'b1;
            pc_we_nxt  = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (cls == CLS_LOAD) begin
          state_nxt = ST_WB;
          aluop_nxt = dec_aluop;
          wb_nxt    = 1'b0;
          regrw_nxt = 1'b1;
          pc_we_nxt = 1'b1;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FETCH;
      ir          <= '0;
      alusrc      <= 1'b0;
      aluop       <= ALU_ADD;
      memrw       <= 1'b0;
      wb          <= 1'b0;
      regrw       <= 1'b0;
      immgen_ctrl <= IMM_I;
      pc_we       <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instret     <= '0;
    end else begin
      state       <= state_nxt;
      if (state == ST_FETCH) begin
        ir <= instr;
      end
      alusrc      <= alusrc_nxt;
      aluop       <= aluop_nxt;
      memrw       <= memrw_nxt;
      wb          <= wb_nxt;
      regrw       <= regrw_nxt;
      immgen_ctrl <= imm_nxt;
      pc_we       <= pc_we_nxt;
      halted      <= halted | set_halt;
      illegal     <= illegal | set_illegal;
      if (pc_we) begin
        instret <= instret + INSTRET_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm
//   Directed self-checking bench for ctrl_fsm. Each instruction is driven
//   from a negedge inside FETCH; outputs are sampled on every negedge and
//   compared against hand-computed cycle positions and values.
module tb_ctrl_fsm;
  import ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [4:0]  status;
  logic        pcsrc, alusrc, memrw, wb, regrw, pc_we, halted, illegal;
  logic [3:0]  aluop;
  logic [1:0]  immgen_ctrl;
  logic [15:0] instret;

  ctrl_fsm #(.INSTRET_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .status      (status),
    .pcsrc       (pcsrc),
    .alusrc      (alusrc),
    .aluop       (aluop),
    .memrw       (memrw),
    .wb          (wb),
    .regrw       (regrw),
    .immgen_ctrl (immgen_ctrl),
    .pc_we       (pc_we),
    .halted      (halted),
    .illegal     (illegal),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_instret = 0;

  logic       s_pcwe   [1:24];
  logic       s_regrw  [1:24];
  logic       s_memrw  [1:24];
  logic       s_wb     [1:24];
  logic       s_alusrc [1:24];
  logic       s_pcsrc  [1:24];
  logic       s_halted [1:24];
  logic       s_illegal[1:24];
  logic [3:0] s_aluop  [1:24];
  logic [1:0] s_imm    [1:24];
  int unsigned cnt_pcwe, cnt_regrw, cnt_memrw;
  int unsigned cyc_pcwe, cyc_regrw, cyc_memrw;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the DUT sits in FETCH (cycle 1); returns at
  // the negedge of the cycle following the last recorded one.
  task automatic run_instr(input logic [31:0] word, input logic [4:0] st, input int unsigned ncyc);
    instr = word;
    status = st;
    cnt_pcwe = 0; cnt_regrw = 0; cnt_memrw = 0;
    cyc_pcwe = 0; cyc_regrw = 0; cyc_memrw = 0;
    for (int unsigned c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge clk);
      s_pcwe[c]    = pc_we;
      s_regrw[c]   = regrw;
      s_memrw[c]   = memrw;
      s_wb[c]      = wb;
      s_alusrc[c]  = alusrc;
      s_pcsrc[c]   = pcsrc;
      s_halted[c]  = halted;
      s_illegal[c] = illegal;
      s_aluop[c]   = aluop;
      s_imm[c]     = immgen_ctrl;
      if (pc_we) begin cnt_pcwe++;  cyc_pcwe = c;  end
      if (regrw) begin cnt_regrw++; cyc_regrw = c; end
      if (memrw) begin cnt_memrw++; cyc_memrw = c; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_instret = 0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, pc_we, halted, illegal});
  endfunction

  initial begin
    rst = 1'b0;
    instr = '0;
    status = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_outs", all_outs(), 32'h0);
    check_eq("reset_instret", 32'(instret), 32'h0);
    rst = 1'b1;

    // ADD x3,x1,x2
    run_instr(32'h002081B3, 5'b00000, 4);
    exp_instret++;
    check_eq("add_pcwe_cyc", cyc_pcwe, 4);
    check_eq("add_pcwe_cnt", cnt_pcwe, 1);
    check_eq("add_regrw_cyc", cyc_regrw, 4);
    check_eq("add_regrw_cnt", cnt_regrw, 1);
    check_eq("add_wb", 32'(s_wb[4]), 32'h1);
    check_eq("add_alusrc", 32'(s_alusrc[4]), 32'h1);
    check_eq("add_pcsrc_wb", 32'(s_pcsrc[4]), 32'h0);
    check_eq("add_aluop", 32'(s_aluop[3]), 32'(ALU_ADD));
    check_eq("add_memrw_cnt", cnt_memrw, 0);
    check_eq("add_instret_pre", 32'(s_pcwe[3]), 32'h0);
    check_eq("add_instret", 32'(instret), exp_instret);

    // SUB x4,x1,x2
    run_instr(32'h40208233, 5'b00000, 4);
    exp_instret++;
    check_eq("sub_aluop", 32'(s_aluop[3]), 32'(ALU_SUB));
    check_eq("sub_pcwe_cyc", cyc_pcwe, 4);

    // ADDI with bit30 set stays ADD, immediate operand
    run_instr(32'h40000093, 5'b00000, 4);
    exp_instret++;
    check_eq("addi_aluop", 32'(s_aluop[3]), 32'(ALU_ADD));
    check_eq("addi_alusrc", 32'(s_alusrc[3]), 32'h0);
    check_eq("addi_regrw_cyc", cyc_regrw, 4);

    // SRAI x1,x1,3
    run_instr(32'h4030D093, 5'b00000, 4);
    exp_instret++;
    check_eq("srai_aluop", 32'(s_aluop[3]), 32'(ALU_SRA));

    // LW x3,0(x1)
    run_instr(32'h0000A183, 5'b00000, 5);
    exp_instret++;
    check_eq("lw_memrw_cnt", cnt_memrw, 0);
    check_eq("lw_regrw_cyc", cyc_regrw, 5);
    check_eq("lw_wb", 32'(s_wb[5]), 32'h0);
    check_eq("lw_imm", 32'(s_imm[3]), 32'(IMM_I));
    check_eq("lw_pcwe_cyc", cyc_pcwe, 5);
    check_eq("lw_pcwe_cnt", cnt_pcwe, 1);
    check_eq("lw_aluop", 32'(s_aluop[3]), 32'(ALU_ADD));
    check_eq("lw_instret", 32'(instret), exp_instret);

    // SW x2,0(x1)
    run_instr(32'h0020A023, 5'b00000, 4);
    exp_instret++;
    check_eq("sw_memrw_cyc", cyc_memrw, 4);
    check_eq("sw_memrw_cnt", cnt_memrw, 1);
    check_eq("sw_imm_mem", 32'(s_imm[4]), 32'(IMM_S));
    check_eq("sw_imm_exec", 32'(s_imm[3]), 32'(IMM_S));
    check_eq("sw_regrw_cnt", cnt_regrw, 0);
    check_eq("sw_pcwe_cyc", cyc_pcwe, 4);
    check_eq("sw_instret", 32'(instret), exp_instret);

    // BEQ taken (z=1)
    run_instr(32'h00208463, 5'b00001, 3);
    exp_instret++;
    check_eq("beq_pcwe_cyc", cyc_pcwe, 3);
    check_eq("beq_pcsrc", 32'(s_pcsrc[3]), 32'h1);
    check_eq("beq_alusrc", 32'(s_alusrc[3]), 32'h1);
    check_eq("beq_aluop", 32'(s_aluop[3]), 32'(ALU_SUB));
    check_eq("beq_imm", 32'(s_imm[3]), 32'(IMM_B));
    check_eq("beq_regrw_cnt", cnt_regrw, 0);

    // BNE not taken (z=1)
    run_instr(32'h00209463, 5'b00001, 3);
    exp_instret++;
    check_eq("bne_pcwe_cyc", cyc_pcwe, 3);
    check_eq("bne_pcsrc", 32'(s_pcsrc[3]), 32'h0);

    // BLT taken (n=1, o=0)
    run_instr(32'h0020C463, 5'b00010, 3);
    exp_instret++;
    check_eq("blt_pcsrc", 32'(s_pcsrc[3]), 32'h1);

    // BGE taken (n=1, o=1)
    run_instr(32'h0020D463, 5'b01010, 3);
    exp_instret++;
    check_eq("bge_t_pcsrc", 32'(s_pcsrc[3]), 32'h1);

    // BGE not taken (n=1, o=0)
    run_instr(32'h0020D463, 5'b00010, 3);
    exp_instret++;
    check_eq("bge_n_pcsrc", 32'(s_pcsrc[3]), 32'h0);
    check_eq("branch_instret", 32'(instret), exp_instret);

    // Illegal opcode
    do_reset();
    run_instr(32'hFFFFFFFF, 5'b00000, 22);
    check_eq("ill_halted_dec", 32'(s_halted[2]), 32'h0);
    check_eq("ill_halted", 32'(s_halted[3]), 32'h1);
    check_eq("ill_illegal", 32'(s_illegal[3]), 32'h1);
    check_eq("ill_strobes", cnt_pcwe + cnt_regrw + cnt_memrw, 0);
    check_eq("ill_halted_end", 32'(s_halted[22]), 32'h1);
    check_eq("ill_instret", 32'(instret), 32'h0);

    // ECALL
    do_reset();
    run_instr(32'h00000073, 5'b00000, 22);
    check_eq("ecall_halted", 32'(s_halted[3]), 32'h1);
    check_eq("ecall_illegal", 32'(s_illegal[22]), 32'h0);
    check_eq("ecall_strobes", cnt_pcwe + cnt_regrw + cnt_memrw, 0);

    // Branch with unsupported funct3 traps after EXEC
    do_reset();
    run_instr(32'h0020A463, 5'b00001, 8);
    check_eq("bill_pcwe_cnt", cnt_pcwe, 0);
    check_eq("bill_halted", 32'(s_halted[4]), 32'h1);
    check_eq("bill_illegal", 32'(s_illegal[4]), 32'h1);

    // Reset during the MEM cycle of a SW
    do_reset();
    run_instr(32'h002081B3, 5'b00000, 4);
    check_eq("pre_rst_instret", 32'(instret), 32'h1);
    instr = 32'h0020A023;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("mem_memrw", 32'(memrw), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("rst_memrw", 32'(memrw), 32'h0);
    check_eq("rst_outs", all_outs(), 32'h0);
    check_eq("rst_instret", 32'(instret), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    exp_instret = 0;
    run_instr(32'h002081B3, 5'b00000, 4);
    exp_instret++;
    check_eq("rel_outs_c1", 32'({s_pcwe[1], s_regrw[1], s_memrw[1]}), 32'h0);
    check_eq("rel_pcwe_cyc", cyc_pcwe, 4);
    check_eq("rel_instret", 32'(instret), exp_instret);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
